// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains an async FIFO read port into a valid/ready stream
// through a 2-entry skid buffer, counting delivered words.
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             rd_en,
  input  logic             flush,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [1:0]       occ,
  output logic [CNTW-1:0]  wcount
);
  logic [1:0]       occ_q, occ_d;
  logic [DSIZE-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [CNTW-1:0]  wc_q, wc_d;
  logic             rdy_q, rdy_d;
  logic             pop, xfer;
  // rdy_q holds off popping until the first edge after reset release
  always_comb begin
    rdy_d = 1'b1;
    pop   = rdy_q & rd_en & ~rempty & ~flush & ~occ_q[1];
    xfer  = (occ_q != 2'd0) & m_ready & ~flush;
    occ_d = flush ? 2'd0 : occ_q + {1'b0, pop} - {1'b0, xfer};
    s0_d  = xfer ? (occ_q[1] ? s1_q : pop ? rdata : s0_q)
                 : (pop && occ_q == 2'd0) ? rdata : s0_q;
    s1_d  = (pop && !xfer && occ_q == 2'd1) ? rdata : s1_q;
    wc_d  = wc_q + CNTW'(xfer);
  end
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      occ_q <= '0;
      s0_q  <= '0;
      s1_q  <= '0;
      wc_q  <= '0;
      rdy_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      wc_q  <= wc_d;
      rdy_q <= rdy_d;
    end
  end
  assign rinc    = pop;
  assign m_valid = occ_q != 2'd0;
  assign m_data  = s0_q;
  assign occ     = occ_q;
  assign wcount  = wc_q;
endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DSIZE, default 8, data width in bits; SHALL match the DSIZE of the async FIFO read port it drains.
REQ-002 Parameter CNTW, default 16, width of the delivered-word counter.
REQ-003 rclk  input  1  sole clock; every flop SHALL be clocked on its rising edge.
REQ-004 rrst_n  input  1  reset, asynchronous assert, active-low; polarity and synchronicity are fixed.
REQ-005 rdata  input  DSIZE  FIFO read data; combinational from FIFO memory; valid whenever rempty=0.
REQ-006 rempty  input  1  FIFO empty flag, registered in the rclk domain.
REQ-007 rinc  output  1  FIFO pop request; a pop occurs at a rising rclk edge when rinc=1 and rempty=0.
REQ-008 rd_en  input  1  1 = block may pop the FIFO; 0 = no new pops; buffered words still drain.
REQ-009 flush  input  1  synchronous discard of all buffered words.
REQ-010 m_data  output  DSIZE  stream data to the consumer.
REQ-011 m_valid  output  1  m_data holds a valid word.
REQ-012 m_ready  input  1  consumer accepts m_data; a transfer occurs on an edge with m_valid=1 and m_ready=1.
REQ-013 occ  output  2  number of words held in the internal buffer, 0..2.
REQ-014 wcount  output  CNTW  count of stream transfers since reset.

Function
REQ-015 The block SHALL contain a 2-entry FIFO-ordered skid buffer (slot0 = head, slot1 = tail) plus a 2-bit occupancy register.
REQ-016 rinc SHALL equal rd_en & ~rempty & ~flush & (occ<2), and SHALL have no combinational path from m_ready.
REQ-017 On a pop edge (rinc=1, rempty=0) the block SHALL capture rdata into the next free slot, or into slot0 if slot0 is also leaving on that edge.
REQ-018 m_valid SHALL equal (occ!=0) and m_data SHALL equal slot0, both driven from registers only.
REQ-019 On a transfer edge, slot1 SHALL shift into slot0 when occ=2.
REQ-020 occ update per edge: +1 on pop only, -1 on transfer only, unchanged on pop plus transfer, unchanged on neither.
REQ-021 Latency: a word present on rdata with rempty=0 and rinc=1 in cycle N SHALL appear on m_data with m_valid=1 in cycle N+1.
REQ-022 Throughput: with rempty=0, rd_en=1 and m_ready=1 held, the block SHALL sustain one transfer per cycle with occ steady at 1.
REQ-023 occ=2 with m_ready=1: rinc=0 that cycle, a transfer occurs and occ becomes 1; the next cycle the block SHALL pop again.
REQ-024 m_data and m_valid SHALL stay stable while m_valid=1 and m_ready=0.
REQ-025 flush=1 SHALL force occ to 0 on the next edge, SHALL suppress rinc, and SHALL not count a transfer on that edge; FIFO contents are untouched.
REQ-026 wcount SHALL increment by 1 on each transfer edge and wrap from 2^CNTW-1 to 0.
REQ-027 rd_en=0 SHALL not affect transfers of words already buffered.
REQ-028 The block SHALL never pop while rempty=1, and SHALL never overwrite a valid slot.

Reset
REQ-029 While rrst_n=0: occ=0, m_valid=0, wcount=0, slot registers =0, and rinc=0 regardless of the other inputs.
REQ-030 rrst_n deassertion SHALL take effect at the next rclk edge, with no pop on the first edge after release.
REQ-031 Reset mid-stream SHALL discard buffered words without popping the FIFO.

Verification
REQ-032 FIFO holds 0xA1,0xA2,0xA3, rd_en=1, m_ready=1 -> m_data 0xA1,0xA2,0xA3 on consecutive cycles, first word one cycle after the first pop; wcount=3; occ returns to 0.
REQ-033 FIFO holds 4 words, m_ready=0 -> occ reaches 2 after 2 pops, rinc=0 thereafter, m_data holds the first word stable; raising m_ready then delivers all 4 in order with no loss or duplication.
REQ-034 occ=2, flush=1 for one cycle -> occ=0, m_valid=0 next cycle, wcount unchanged, no pop that cycle.
REQ-035 rempty=1 throughout, rd_en=1 -> rinc=0 and m_valid=0 on every cycle.
REQ-036 CNTW=4, 17 transfers -> wcount reads 1.
REQ-037 rrst_n pulsed low while occ=2 -> m_valid=0, occ=0, wcount=0 immediately; no rinc while in reset.
